twofish_block_loader: RTL and testbench
=======================================

# twofish_block_loader

Upstream input stage for the Twofish encrypt datapath. It accepts a 32-bit word stream carrying key words and plaintext words under a valid/ready handshake and assembles them into 128-bit blocks. Each block goes out as a registered 128-bit plaintext together with the 128-bit key captured alongside it, under a valid/ready handshake. The encrypt core consumes `m_text`/`m_key` directly as its `plain_text`/`key` inputs.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  loader can accept a word this cycle.
- `s_kind`  in  1  0 = plaintext word, 1 = key word.
- `s_data`  in  32  input word.
- `m_valid`  out  1  `m_text`/`m_key` hold a complete block.
- `m_ready`  in  1  core accepts the block.
- `m_text`  out  128  assembled plaintext block.
- `m_key`  out  128  key paired with `m_text`.
- `key_valid`  out  1  a full key has been loaded since reset.
- `err`  out  1  one-cycle pulse on protocol error.

## Operation
- Word order: first word of a group lands in [127:96], second in [95:64], third in [63:32], fourth in [31:0].
- Internal state:
  - assembly buffer `asm_buf` (128 bits);
  - `asm_cnt` (0..4);
  - `asm_kind` (kind of the current partial group);
  - active key register `key_q`;
  - output registers.
- States:
  - **EMPTY** (`asm_cnt`=0);
  - **PARTIAL** (`asm_cnt`=1..3);
  - **FULL** (`asm_cnt`=4; only for a completed text group waiting on the output slot).
- `s_ready` = (state != FULL). A handshake is `s_valid && s_ready`.
- EMPTY + handshake: the word is stored and `asm_kind` <= `s_kind`; go to PARTIAL.
- PARTIAL + handshake with `s_kind` != `asm_kind`:
  - the partial group is discarded and `err` pulses;
  - the new word starts a fresh group (`asm_cnt`=1, new kind).
- 4th key word handshake:
  - `key_q` <= assembled key, `key_valid` <= 1, go to EMPTY;
  - a block already in the output slot keeps its previously captured key.
- 4th text word handshake:
  - if `key_valid`=0: the block is dropped, `err` pulses, go to EMPTY;
  - else if the output slot is free (`!m_valid || m_ready`): `m_text` <= block, `m_key` <= `key_q`, `m_valid` <= 1, go to EMPTY;
  - else: go to FULL.
- FULL: when `m_valid && m_ready`, the held block moves into the output registers with `key_q`; `m_valid` stays 1; go to EMPTY.
- Output: `m_valid` clears on `m_ready` unless a new block loads on the same edge.

## Timing
- Reset values:
  - `s_ready`=1 (EMPTY);
  - `m_valid`=0, `m_text`=0, `m_key`=0;
  - `key_valid`=0;
  - `err`=0;
  - `asm_cnt`=0, `key_q`=0.
- Reset mid-group discards the partial group and any pending output; the key must be reloaded.
- Latency: `m_valid` rises the cycle after the 4th text-word handshake when the slot is free; `m_text`/`m_key` are stable whenever `m_valid`=1.
- Throughput:
  - one word per cycle;
  - one block per 4 cycles with `m_ready` held high, no bubbles;
  - a 4th word and an `m_ready` acceptance on the same edge reload the slot back-to-back.
- FULL holds `s_ready`=0 until the slot drains; the transfer and the return to `s_ready`=1 take effect on that same edge.
- `m_ready` while `m_valid`=0 is ignored.
- `err` is registered and high exactly one cycle after the offending handshake.

## Configuration
- `TWOFISH_LOADER_BSWAP_EN` defined:
  - each `s_data` word is byte-reversed before storage (byte 0 becomes MSB), matching Twofish little-endian test-vector order;
  - applies to key and text words.
- Undefined: words are stored as presented.

## Test plan
- Key load then one block:
  - stimulus: key words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, then text words 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210;
  - required: `key_valid`=1 after the 4th key word; one cycle after the last text word, `m_valid`=1, `m_text`=0x0123456789ABCDEFFEDCBA9876543210, `m_key`=0x00112233445566778899AABBCCDDEEFF.
- Backpressure:
  - stimulus: `m_ready`=0, stream 8 text words;
  - required: first block held, second enters FULL, `s_ready`=0; on `m_ready`=1 for one cycle, the second block appears the next cycle, `s_ready`=1, no words lost.
- Key change with a pending block:
  - stimulus: a block waiting with key A, then 4 key words for key B, then release;
  - required: the first output carries `m_key`=A; the next block carries B.
- Kind switch:
  - stimulus: 2 text words then 1 key word;
  - required: `err` pulses once; the group restarts with `asm_cnt`=1 of kind key; no `m_valid`.
- No key loaded:
  - stimulus: 4 text words after reset;
  - required: `err`=1 for one cycle, `m_valid` stays 0.
- Async reset mid-group plus byte swap:
  - stimulus: `rst_n` low after 3 words; with `TWOFISH_LOADER_BSWAP_EN`, key word 0x00112233;
  - required: all outputs at reset values; the swapped word stores as 0x33221100 in [127:96].

Source files
------------

// File: rtl/twofish_block_loader.sv
// Twofish input stage: packs a 32-bit key/plaintext word stream into 128-bit blocks paired with the active key.
// Optional build macro TWOFISH_LOADER_BSWAP_EN byte-reverses every incoming word before it is stored.
module twofish_block_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_kind,
  input  logic [31:0]  s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_text,
  output logic [127:0] m_key,
  output logic         key_valid,
  output logic         err
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and m_text/m_key hold steady while m_valid is high.

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

  localparam logic KIND_KEY = 1'b1;

  state_t         state_q, state_d;
  logic [127:0]   asm_buf_q, asm_buf_d;
  logic [2:0]     asm_cnt_q, asm_cnt_d;
  logic           asm_kind_q, asm_kind_d;
  logic [127:0]   key_q, key_d;
  logic           key_valid_q, key_valid_d;
  logic           m_valid_q, m_valid_d;
  logic [127:0]   m_text_q, m_text_d;
  logic [127:0]   m_key_q, m_key_d;
  logic           err_q, err_d;

  logic           hs;
  logic [31:0]    word_in;
  logic [127:0]   block;
  logic           slot_free;

  function automatic logic [31:0] prep_word(input logic [31:0] w);
`ifdef TWOFISH_LOADER_BSWAP_EN
    prep_word = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    prep_word = w;
`endif
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      asm_buf_q   <= '0;
      asm_cnt_q   <= '0;
      asm_kind_q  <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_text_q    <= '0;
      m_key_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_buf_q   <= asm_buf_d;
      asm_cnt_q   <= asm_cnt_d;
      asm_kind_q  <= asm_kind_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      m_valid_q   <= m_valid_d;
      m_text_q    <= m_text_d;
      m_key_q     <= m_key_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    hs          = s_valid && s_ready;
    word_in     = prep_word(s_data);
    block       = {asm_buf_q[127:32], word_in};
    slot_free   = !m_valid_q || m_ready;

    state_d     = state_q;
    asm_buf_d   = asm_buf_q;
    asm_cnt_d   = asm_cnt_q;
    asm_kind_d  = asm_kind_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    m_valid_d   = m_valid_q && !m_ready;
    m_text_d    = m_text_q;
    m_key_d     = m_key_q;
    err_d       = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (hs) begin
          asm_buf_d  = {word_in, 96'd0};
          asm_cnt_d  = 3'd1;
          asm_kind_d = s_kind;
          state_d    = ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (hs) begin
          if (s_kind != asm_kind_q) begin
            // Kind switch mid-group: drop what was gathered and restart with this word.
            err_d      = 1'b1;
            asm_buf_d  = {word_in, 96'd0};
            asm_cnt_d  = 3'd1;
            asm_kind_d = s_kind;
          end else if (asm_cnt_q == 3'd3) begin
            asm_cnt_d = 3'd0;
            state_d   = ST_EMPTY;
            if (asm_kind_q == KIND_KEY) begin
              key_d       = block;
              key_valid_d = 1'b1;
            end else if (!key_valid_q) begin
              err_d = 1'b1;
            end else if (slot_free) begin
              m_text_d  = block;
              m_key_d   = key_q;
              m_valid_d = 1'b1;
            end else begin
              asm_buf_d = block;
              asm_cnt_d = 3'd4;
              state_d   = ST_FULL;
            end
          end else begin
            case (asm_cnt_q)
              3'd1:    asm_buf_d[95:64] = word_in;
              default: asm_buf_d[63:32] = word_in;
            endcase
            asm_cnt_d = asm_cnt_q + 3'd1;
          end
        end
      end
      ST_FULL: begin
        // Input is stalled here, so key_q is still the key that was active when the block completed.
        if (m_valid_q && m_ready) begin
          m_text_d  = asm_buf_q;
          m_key_d   = key_q;
          m_valid_d = 1'b1;
          asm_cnt_d = 3'd0;
          state_d   = ST_EMPTY;
        end
      end
      default: begin
        state_d   = ST_EMPTY;
        asm_cnt_d = 3'd0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    s_ready   = (state_q != ST_FULL);
    m_valid   = m_valid_q;
    m_text    = m_text_q;
    m_key     = m_key_q;
    key_valid = key_valid_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_twofish_block_loader.sv
// Self-checking bench for twofish_block_loader: directed scenarios with literal expectations plus random traffic vs a group-level model.
module tb_twofish_block_loader;
  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic         s_kind;
  logic [31:0]  s_data;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_text;
  logic [127:0] m_key;
  logic         key_valid;
  logic         err;

  int checks = 0;
  int errors = 0;

`ifdef TWOFISH_LOADER_BSWAP_EN
  localparam logic [127:0] KEY_A = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
  localparam logic [127:0] TXT_A = 128'h67452301_EFCDAB89_98BADCFE_10325476;
  localparam logic [31:0]  KEY_A_TOP = 32'h33221100;
`else
  localparam logic [127:0] KEY_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] TXT_A = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [31:0]  KEY_A_TOP = 32'h00112233;
`endif

  twofish_block_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_kind    (s_kind),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_text    (m_text),
    .m_key     (m_key),
    .key_valid (key_valid),
    .err       (err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: words collected into a group queue, one output slot, one pending block.
  logic [31:0]  grp[$];
  logic         grp_kind;
  logic [127:0] mk;
  logic         mkv;
  logic         mov;
  logic [127:0] mot, mok;
  logic         mpv;
  logic [127:0] mpt;
  logic         merr;

  function automatic logic [31:0] bsw(input logic [31:0] w);
`ifdef TWOFISH_LOADER_BSWAP_EN
    bsw = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    bsw = w;
`endif
  endfunction

  always @(posedge clk) begin : model_upd
    logic [127:0] blk;
    logic         hs_m;
    logic         nov;
    logic         nerr;
    if (!rst_n) begin
      grp.delete();
      grp_kind = 1'b0;
      mk = '0; mkv = 1'b0; mov = 1'b0; mot = '0; mok = '0;
      mpv = 1'b0; mpt = '0; merr = 1'b0;
    end else begin
      hs_m = s_valid && !mpv;
      nerr = 1'b0;
      nov  = mov && !m_ready;
      if (mpv && mov && m_ready) begin
        mot = mpt; mok = mk; nov = 1'b1; mpv = 1'b0;
      end
      if (hs_m) begin
        if (grp.size() != 0 && grp_kind != s_kind) begin
          grp.delete();
          nerr = 1'b1;
        end
        grp.push_back(bsw(s_data));
        grp_kind = s_kind;
        if (grp.size() == 4) begin
          blk = {grp[0], grp[1], grp[2], grp[3]};
          grp.delete();
          if (s_kind) begin
            mk = blk; mkv = 1'b1;
          end else if (!mkv) begin
            nerr = 1'b1;
          end else if (!mov || m_ready) begin
            mot = blk; mok = mk; nov = 1'b1;
          end else begin
            mpv = 1'b1; mpt = blk;
          end
        end
      end
      mov  = nov;
      merr = nerr;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_ready", 128'(s_ready), 128'd1);
      chk("rst_m_valid", 128'(m_valid), 128'd0);
      chk("rst_m_text", m_text, 128'd0);
      chk("rst_m_key", m_key, 128'd0);
      chk("rst_key_valid", 128'(key_valid), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
    end else begin
      chk("s_ready", 128'(s_ready), 128'(!mpv));
      chk("m_valid", 128'(m_valid), 128'(mov));
      if (mov) begin
        chk("m_text", m_text, mot);
        chk("m_key", m_key, mok);
      end
      chk("key_valid", 128'(key_valid), 128'(mkv));
      chk("err", 128'(err), 128'(merr));
    end
  end

  // Driver tasks
  task automatic send(input logic k, input logic [31:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_kind  = k;
    s_data  = d;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=s_ready_low exp=s_ready_high");
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_grp(input logic k, input logic [127:0] b);
    send(k, b[127:96]);
    send(k, b[95:64]);
    send(k, b[63:32]);
    send(k, b[31:0]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic cur_kind;
    rst_n = 1'b0; s_valid = 1'b0; s_kind = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("lit_reset_s_ready", 128'(s_ready), 128'd1);

    // Key load then one block
    m_ready = 1'b1;
    send_grp(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("lit_key_valid", 128'(key_valid), 128'd1);
    send_grp(1'b0, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    chk("lit_blk_m_valid", 128'(m_valid), 128'd1);
    chk("lit_blk_m_text", m_text, TXT_A);
    chk("lit_blk_m_key", m_key, KEY_A);
    chk("lit_key_top", 128'(m_key[127:96]), 128'(KEY_A_TOP));

    // Backpressure: two blocks, the second parks in the loader
    @(negedge clk);
    m_ready = 1'b0;
    send_grp(1'b0, 128'h11111111_22222222_33333333_44444444);
    send_grp(1'b0, 128'h55555555_66666666_77777777_88888888);
    chk("lit_bp_s_ready", 128'(s_ready), 128'd0);
    chk("lit_bp_first", m_text, 128'h11111111_22222222_33333333_44444444);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("lit_bp_second", m_text, 128'h55555555_66666666_77777777_88888888);
    chk("lit_bp_m_valid", 128'(m_valid), 128'd1);
    chk("lit_bp_ready_back", 128'(s_ready), 128'd1);
    m_ready = 1'b1;
    @(negedge clk);
    chk("lit_bp_drained", 128'(m_valid), 128'd0);

    // Key change while a block waits in the slot
    m_ready = 1'b0;
    send_grp(1'b0, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC);
    send_grp(1'b1, 128'hDDDDDDDD_EEEEEEEE_FFFFFFFF_12121212);
    chk("lit_kc_old_key", m_key, KEY_A);
    send_grp(1'b0, 128'h34343434_56565656_78787878_9A9A9A9A);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("lit_kc_text", m_text, 128'h34343434_56565656_78787878_9A9A9A9A);
    chk("lit_kc_new_key", m_key, 128'hDDDDDDDD_EEEEEEEE_FFFFFFFF_12121212);
    m_ready = 1'b1;
    @(negedge clk);

    // Kind switch mid-group
    send(1'b0, 32'h01010101);
    send(1'b0, 32'h02020202);
    send(1'b1, 32'h0A0A0A0A);
    chk("lit_ks_err", 128'(err), 128'd1);
    @(negedge clk);
    chk("lit_ks_err_drop", 128'(err), 128'd0);
    chk("lit_ks_no_valid", 128'(m_valid), 128'd0);
    send(1'b1, 32'h0B0B0B0B);
    send(1'b1, 32'h0C0C0C0C);
    send(1'b1, 32'h0D0D0D0D);
    send_grp(1'b0, 128'h1A1A1A1A_1B1B1B1B_1C1C1C1C_1D1D1D1D);
    chk("lit_ks_key", m_key, 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D);

    // No key loaded
    do_reset();
    send_grp(1'b0, 128'h21212121_22222222_23232323_24242424);
    chk("lit_nokey_err", 128'(err), 128'd1);
    chk("lit_nokey_valid", 128'(m_valid), 128'd0);
    @(negedge clk);
    chk("lit_nokey_err_drop", 128'(err), 128'd0);

    // Reset mid-group, then reload
    send(1'b1, 32'h00112233);
    send(1'b1, 32'h44556677);
    send(1'b1, 32'h8899AABB);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("lit_mid_rst_kv", 128'(key_valid), 128'd0);
    chk("lit_mid_rst_ready", 128'(s_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_grp(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    send_grp(1'b0, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    chk("lit_rl_key", m_key, KEY_A);
    chk("lit_rl_text", m_text, TXT_A);

    // Random traffic
    cur_kind = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (i == 600) begin
        #1 rst_n = 1'b0;
      end else if (i == 603) begin
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 11) == 0) cur_kind = ~cur_kind;
      s_valid = ($urandom_range(0, 3) != 0);
      s_kind  = cur_kind;
      s_data  = $urandom;
      m_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
